// File: rtl/pc_sequencer_if.sv
// Memory handshake bundle between the instruction sequencer and the memory port.
// The sequencer is the master and raises requests; memory answers with a single-cycle ack.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             memReq;
    logic             memWe;
    logic             memSelPc;
    logic             memAck;
    logic [WIDTH-1:0] memRdata;

    modport master (
        output memReq,
        output memWe,
        output memSelPc,
        input  memAck,
        input  memRdata
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memSelPc,
        output memAck,
        output memRdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CR16-style core.
// It holds the IR and the branch decision, and drives the PC-ALU selects and the write strobes.
module pc_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [4:0]       psrFlags,
    pc_sequencer_if.master   mem,
    output logic [WIDTH-1:0] ir,
    output logic             irWe,
    output logic             jumpEn,
    output logic             jalEn,
    output logic             branchEn,
    output logic             pcWe,
    output logic             linkWe,
    output logic             regWe,
    output logic             psrWe,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } stateT;

    stateT            curState;
    logic [WIDTH-1:0] irReg;
    logic             taken;
    logic             fetchActive;

    logic [3:0] opHi;
    logic [3:0] opLo;
    logic [3:0] cond;
    logic       isBcond;
    logic       isJcond;
    logic       isJal;
    logic       isLoad;
    logic       isStor;
    logic       isAlu;
    logic       isCmp;
    logic       condMet;
    logic       fetchReq;
    logic       inWb;

    assign opHi = irReg[15:12];
    assign opLo = irReg[7:4];
    assign cond = irReg[11:8];

    assign isBcond = (opHi == 4'b1100);
    assign isJcond = (opHi == 4'b0100) && (opLo == 4'b1100);
    assign isJal   = (opHi == 4'b0100) && (opLo == 4'b1000);
    assign isLoad  = (opHi == 4'b0100) && (opLo == 4'b0000);
    assign isStor  = (opHi == 4'b0100) && (opLo == 4'b0100);
    assign isAlu   = !(isBcond || isJcond || isJal || isLoad || isStor);
    assign isCmp   = ((opHi == 4'b0000) && (opLo == 4'b1011)) || (opHi == 4'b1011);

    // Condition codes over {N,Z,F,L,C}; only consulted in EXEC and then latched into taken.
    always_comb begin
        condMet = 1'b0;
        case (cond)
            4'b0000: condMet = psrFlags[3];
            4'b0001: condMet = !psrFlags[3];
            4'b0010: condMet = psrFlags[0];
            4'b0011: condMet = !psrFlags[0];
            4'b0100: condMet = psrFlags[1];
            4'b0101: condMet = !psrFlags[1];
            4'b0110: condMet = psrFlags[4];
            4'b0111: condMet = !psrFlags[4];
            4'b1000: condMet = psrFlags[2];
            4'b1001: condMet = !psrFlags[2];
            4'b1010: condMet = !psrFlags[1] && !psrFlags[3];
            4'b1011: condMet = psrFlags[1] || psrFlags[3];
            4'b1100: condMet = !psrFlags[4] && !psrFlags[3];
            4'b1101: condMet = psrFlags[4] || psrFlags[3];
            4'b1110: condMet = 1'b1;
            default: condMet = 1'b0;
        endcase
    end

    // fetchActive keeps an issued fetch request alive even if run drops before the ack.
    assign fetchReq = (curState == FETCH) && (run || fetchActive);
    assign inWb     = (curState == WB);

    // Main sequencer; an asserted reset abandons any outstanding memory access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState    <= FETCH;
            irReg       <= '0;
            taken       <= 1'b0;
            fetchActive <= 1'b0;
        end else begin
            case (curState)
                FETCH: begin
                    if (fetchReq && mem.memAck) begin
                        irReg       <= mem.memRdata;
                        fetchActive <= 1'b0;
                        curState    <= DECODE;
                    end else begin
                        fetchActive <= fetchReq;
                    end
                end
                DECODE: curState <= EXEC;
                EXEC: begin
                    taken    <= (isBcond || isJcond) && condMet;
                    curState <= (isLoad || isStor) ? MEM : WB;
                end
                MEM: begin
                    if (mem.memAck) begin
                        curState <= WB;
                    end
                end
                WB:      curState <= FETCH;
                default: curState <= FETCH;
            endcase
        end
    end

    // The memory-side outputs also see reset directly so they fall in the same instant it asserts.
    assign mem.memReq   = reset && (fetchReq || (curState == MEM));
    assign mem.memSelPc = reset && fetchReq;
    assign mem.memWe    = reset && (curState == MEM) && isStor;
    assign irWe         = reset && fetchReq && mem.memAck;

    assign psrWe    = (curState == EXEC) && isAlu;
    assign pcWe     = inWb;
    assign jalEn    = inWb && isJal;
    assign linkWe   = inWb && isJal;
    assign jumpEn   = inWb && isJcond && taken;
    assign branchEn = inWb && isBcond && taken;
    assign regWe    = inWb && ((isAlu && !isCmp) || isLoad);

    assign ir    = irReg;
    assign state = curState;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed and random instructions compared
// cycle by cycle against a per-instruction model of the state walk and strobes.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [4:0]  psrFlags;
    logic [15:0] ir;
    logic        irWe;
    logic        jumpEn;
    logic        jalEn;
    logic        branchEn;
    logic        pcWe;
    logic        linkWe;
    logic        regWe;
    logic        psrWe;
    logic [2:0]  state;

    int checks = 0;
    int fails  = 0;

    pc_sequencer_if #(.WIDTH(16)) memBus ();

    pc_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .psrFlags (psrFlags),
        .mem      (memBus),
        .ir       (ir),
        .irWe     (irWe),
        .jumpEn   (jumpEn),
        .jalEn    (jalEn),
        .branchEn (branchEn),
        .pcWe     (pcWe),
        .linkWe   (linkWe),
        .regWe    (regWe),
        .psrWe    (psrWe),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {state, memReq, memWe, memSelPc, irWe, jumpEn, jalEn, branchEn, pcWe, linkWe, regWe, psrWe}.
    function automatic logic [13:0] mkExp(input logic [2:0] st, input logic req, input logic we,
                                          input logic sel, input logic irw, input logic jmp,
                                          input logic jal, input logic br, input logic pc,
                                          input logic lnk, input logic rg, input logic psr);
        return {st, req, we, sel, irw, jmp, jal, br, pc, lnk, rg, psr};
    endfunction

    // Architectural meaning of each condition code over {N,Z,F,L,C}.
    function automatic bit condTrue(input logic [3:0] c, input logic [4:0] f);
        bit n, z, fl, l, cy;
        {n, z, fl, l, cy} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return l;
            4'd5:    return !l;
            4'd6:    return n;
            4'd7:    return !n;
            4'd8:    return fl;
            4'd9:    return !fl;
            4'd10:   return !l && !z;
            4'd11:   return l || z;
            4'd12:   return !n && !z;
            4'd13:   return n || z;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        #1;
        obs = {state, memBus.memReq, memBus.memWe, memBus.memSelPc, irWe, jumpEn, jalEn,
               branchEn, pcWe, linkWe, regWe, psrWe};
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkIr(input string tag, input logic [15:0] exp);
        checks++;
        assert (ir === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed ir %h required %h", tag, ir, exp);
        end
    endtask

    // Runs one instruction from its first FETCH cycle through WB, checking every cycle.
    task automatic applyStimulus(input string tag, input logic [15:0] instr, input logic [4:0] flags,
                                 input int fetchWait, input int memWait);
        logic [3:0] hi, lo;
        bit bc, jc, jl, ld, st, alu, cmp, tk;
        hi  = instr[15:12];
        lo  = instr[7:4];
        bc  = (hi == 4'hC);
        jc  = (hi == 4'h4) && (lo == 4'hC);
        jl  = (hi == 4'h4) && (lo == 4'h8);
        ld  = (hi == 4'h4) && (lo == 4'h0);
        st  = (hi == 4'h4) && (lo == 4'h4);
        alu = !(bc || jc || jl || ld || st);
        cmp = ((hi == 4'h0) && (lo == 4'hB)) || (hi == 4'hB);
        tk  = (bc || jc) && condTrue(instr[11:8], flags);

        for (int k = 0; k <= fetchWait; k++) begin
            run             = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            memBus.memAck   = (k == fetchWait);
            memBus.memRdata = (k == fetchWait) ? instr : 16'($urandom);
            checkOutput({tag, ".fetch"}, mkExp(3'd0, 1, 0, 1, (k == fetchWait), 0, 0, 0, 0, 0, 0, 0));
        end
        run             = 1'b1;
        memBus.memAck   = 1'($urandom_range(0, 1));
        memBus.memRdata = 16'($urandom);
        checkOutput({tag, ".decode"}, mkExp(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        psrFlags      = flags;
        memBus.memAck = 1'($urandom_range(0, 1));
        checkOutput({tag, ".exec"}, mkExp(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, alu));
        if (ld || st) begin
            for (int k = 0; k <= memWait; k++) begin
                memBus.memAck = (k == memWait);
                checkOutput({tag, ".mem"}, mkExp(3'd3, 1, st, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
        end
        psrFlags      = 5'($urandom);
        memBus.memAck = 1'($urandom_range(0, 1));
        checkIr({tag, ".ir"}, instr);
        checkOutput({tag, ".wb"}, mkExp(3'd4, 0, 0, 0, 0, jc && tk, jl, bc && tk, 1, jl,
                                        (alu && !cmp) || ld, 0));
        memBus.memAck = 1'b0;
    endtask

    initial begin
        logic [3:0] hiPick [8];
        logic [3:0] loPick [6];
        logic [15:0] rnd;
        hiPick = '{4'h0, 4'h1, 4'h4, 4'h4, 4'h4, 4'hB, 4'hC, 4'h7};
        loPick = '{4'h0, 4'h4, 4'h8, 4'hB, 4'hC, 4'h5};

        reset           = 1'b0;
        run             = 1'b1;
        psrFlags        = 5'b0;
        memBus.memAck   = 1'b0;
        memBus.memRdata = 16'h0;
        checkOutput("resetHeld", 14'b0);
        checkIr("resetIr", 16'h0000);
        reset = 1'b1;

        // Reset dropped in the middle of a fetch handshake.
        checkOutput("preReset.fetch", mkExp(3'd0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        checkOutput("midFetchReset", 14'b0);
        reset = 1'b1;

        applyStimulus("add",      16'h0152, 5'b00000, 2, 0);
        applyStimulus("beqTaken", 16'hC005, 5'b01000, 0, 0);
        applyStimulus("beqNot",   16'hC005, 5'b10111, 1, 0);
        applyStimulus("bNever",   16'hCF05, 5'b11111, 0, 0);
        applyStimulus("bAlways",  16'hCE05, 5'b00000, 0, 0);
        applyStimulus("jal",      16'h4E8A, 5'b01010, 1, 0);
        applyStimulus("jcond",    16'h42CA, 5'b00001, 0, 0);
        applyStimulus("jcLo",     16'h4ACA, 5'b10100, 0, 0);
        applyStimulus("load",     16'h4302, 5'b00000, 0, 4);
        applyStimulus("stor",     16'h4544, 5'b00000, 0, 4);
        applyStimulus("cmpA",     16'h00B1, 5'b00000, 0, 0);
        applyStimulus("cmpB",     16'hB123, 5'b00000, 0, 0);

        run           = 1'b0;
        memBus.memAck = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("idle", 14'b0);
        end

        for (int i = 0; i < 40; i++) begin
            rnd = {hiPick[$urandom_range(0, 7)], 4'($urandom), loPick[$urandom_range(0, 5)], 4'($urandom)};
            applyStimulus("rand", rnd, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
